mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Responder side of the cache-to-memory request protocol.
- Accepts word requests from the instruction cache (read-only) and the data cache (read/write) and serialises them onto the single-ported RAM.
- Drives the per-cache wait/load responses. Sits between icache/dcache and the RAM model, in place of a purely combinational memory controller.

Parameters:
- WORD_W, 32, data and address width in bits.
- MAX_RETRY, 3, number of consecutive RAM ERROR cycles tolerated per access before the access is force-completed.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; asynchronous, active-low.
- iREN  in  1  instruction cache read request.
- iaddr  in  WORD_W  instruction read address.
- iwait  out  1  low for exactly one cycle when the instruction read completes.
- iload  out  WORD_W  instruction read data; valid only while iwait=0.
- dREN  in  1  data cache read request.
- dWEN  in  1  data cache write request; if dREN and dWEN are both high, dWEN wins.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  data write value.
- dwait  out  1  low for exactly one cycle when the data access completes.
- dload  out  WORD_W  data read value; valid only while dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: 0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.
- ram_err  out  1  sticky flag, set when an access is force-completed after MAX_RETRY errors.

Behaviour:
- States: IDLE, IREAD, DREAD, DWRITE.
- Reset values:
  - state=IDLE.
  - iwait=1, dwait=1.
  - iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - ram_err=0.
  - Retry counter=0, last_grant=I.
- IDLE arbitration, on each rising edge:
  - If a D request (dREN|dWEN) and iREN are both pending, grant D unless last_grant=D, in which case grant I. This alternation prevents starvation.
  - A lone request is granted directly.
  - On grant: latch the address (and dstore for writes) into registers, update last_grant, and move to IREAD/DREAD/DWRITE. Grant decision to RAM enable is 1 cycle.
- In IREAD/DREAD/DWRITE:
  - ramaddr and ramstore come from the latched registers.
  - ramREN=1 in the read states; ramWEN=1 in DWRITE. Never both high.
- Completion occurs when ramstate=ACCESS:
  - Drive the granted cache's wait=0 combinationally in that cycle.
  - For reads, drive the granted cache's load=ramload in that cycle.
  - Return to IDLE on the next edge with the retry counter cleared.
  - Minimum latency from request high to wait low is 2 cycles. Back-to-back requests each incur one IDLE cycle.
- ramstate=FREE or BUSY: hold the current state with wait=1.
- ramstate=ERROR:
  - Increment the retry counter and hold, keeping the request asserted to RAM.
  - If the counter already equals MAX_RETRY, complete the access: wait=0, load=ramload (undefined data), set ram_err, return to IDLE.
- Abort: if the granted request is deasserted before completion, deassert ramREN/ramWEN combinationally, return to IDLE next edge, and generate no wait pulse.
- Address change mid-access is ignored; the latched address is used.
- The non-granted cache sees wait=1 throughout.
- load outputs are 0 whenever their wait is 1.
- Reset asserted mid-access returns immediately to reset values. No completion pulse is generated.

Test Plan:
- Lone iREN, iaddr=0x40, RAM returns ACCESS on the 2nd busy-free cycle with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40; iwait=0 for one cycle with iload=0xDEADBEEF; dwait stays 1.
- dWEN=1, dREN=1, daddr=0x100, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait pulses once at ACCESS.
- iREN and dREN held high continuously, ACCESS every 2nd RAM cycle -> grants alternate D, I, D, I; each wait pulses once per grant.
- ramstate=ERROR for 4 consecutive cycles with MAX_RETRY=3 -> completion on the 4th ERROR cycle and ram_err=1 sticky; a subsequent normal access leaves ram_err=1.
- dREN dropped while in DREAD with ramstate=BUSY -> ramREN falls the same cycle, state returns to IDLE, no dwait pulse.
- nRST pulsed low while in DWRITE -> all outputs at reset values asynchronously; a new iREN after release is serviced normally.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// Cache/RAM request bundle seen by mem_req_arbiter.
// The slave modport is the arbiter's view; master is the cache/RAM side.
interface mem_req_arbiter_if #(
    parameter int unsigned WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              ram_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Serialises icache reads and dcache reads/writes onto a single-ported RAM,
// alternating grants under contention and force-completing after repeated RAM errors.
module mem_req_arbiter #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned MAX_RETRY = 3
) (
    input logic              CLK,
    input logic              nRST,
    mem_req_arbiter_if.slave bus
);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

    state_t             r_state;
    logic [WORD_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_store;
    logic [RETRY_W-1:0] r_retry;
    logic               r_last_d;
    logic               r_err;

    logic w_active;
    logic w_req_live;
    logic w_access;
    logic w_error;
    logic w_retry_max;
    logic w_done;
    logic w_d_req;
    logic w_grant_d;

    assign w_active    = (r_state != IDLE);
    assign w_access    = (bus.ramstate == RAM_ACCESS);
    assign w_error     = (bus.ramstate == RAM_ERROR);
    assign w_retry_max = (r_retry == RETRY_W'(MAX_RETRY));
    assign w_d_req     = bus.dREN | bus.dWEN;
    // D wins a tie unless it had the previous grant
    assign w_grant_d   = w_d_req & (~bus.iREN | ~r_last_d);

    // The granted request must stay asserted; dropping it aborts the access
    always_comb begin
        w_req_live = 1'b0;
        case (r_state)
            IREAD:   w_req_live = bus.iREN;
            DREAD:   w_req_live = bus.dREN;
            DWRITE:  w_req_live = bus.dWEN;
            default: w_req_live = 1'b0;
        endcase
    end

    assign w_done = w_active & w_req_live & (w_access | (w_error & w_retry_max));

    assign bus.ramREN   = w_req_live & ((r_state == IREAD) | (r_state == DREAD));
    assign bus.ramWEN   = w_req_live & (r_state == DWRITE);
    assign bus.ramaddr  = w_active ? r_addr : '0;
    assign bus.ramstore = (r_state == DWRITE) ? r_store : '0;

    assign bus.iwait = ~(w_done & (r_state == IREAD));
    assign bus.iload = (w_done & (r_state == IREAD)) ? bus.ramload : '0;
    assign bus.dwait = ~(w_done & ((r_state == DREAD) | (r_state == DWRITE)));
    assign bus.dload = (w_done & (r_state == DREAD)) ? bus.ramload : '0;
    assign bus.ram_err = r_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_store  <= '0;
            r_retry  <= '0;
            r_last_d <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_retry <= '0;
                    if (w_grant_d) begin
                        r_last_d <= 1'b1;
                        r_addr   <= bus.daddr;
                        r_store  <= bus.dstore;
                        r_state  <= bus.dWEN ? DWRITE : DREAD;
                    end else if (bus.iREN) begin
                        r_last_d <= 1'b0;
                        r_addr   <= bus.iaddr;
                        r_state  <= IREAD;
                    end
                end
                default: begin
                    if (!w_req_live || w_done) begin
                        r_state <= IDLE;
                        r_retry <= '0;
                        if (w_done && w_error) begin
                            r_err <= 1'b1;
                        end
                    end else if (w_error) begin
                        r_retry <= r_retry + RETRY_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: expected completions are queued when
// requests are driven and checked as wait pulses appear.
module tb_mem_req_arbiter;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic nrst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    mem_req_arbiter_if #(.WORD_W(32)) bus ();

    mem_req_arbiter #(.WORD_W(32), .MAX_RETRY(3)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Small RAM model: BUSY for nbusy active cycles then ACCESS; ramload = ramaddr ^ salt.
    task automatic await_pulse(input logic [31:0] salt, input int nbusy, input int budget,
                               output bit seen, output bit is_d, output logic [31:0] load,
                               output logic other_wait);
        int k = 0;
        seen = 1'b0; is_d = 1'b0; load = '0; other_wait = 1'b1;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            bus.ramload = bus.ramaddr ^ salt;
            if (bus.ramREN || bus.ramWEN) begin
                bus.ramstate = (k >= nbusy) ? ACCESS : BUSY;
                k++;
            end else begin
                bus.ramstate = FREE;
            end
            #1;
            if (!bus.iwait) begin
                seen = 1'b1; is_d = 1'b0; load = bus.iload; other_wait = bus.dwait;
            end else if (!bus.dwait) begin
                seen = 1'b1; is_d = 1'b1; load = bus.dload; other_wait = bus.iwait;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({bus.iwait, bus.dwait} !== 2'b11) begin
            errors++; $display("FAIL reset_wait: got %b want 11", {bus.iwait, bus.dwait});
        end
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ram_err} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000", {bus.ramREN, bus.ramWEN, bus.ram_err});
        end
        checks++;
        if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== 128'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {bus.ramaddr, bus.ramstore, bus.iload, bus.dload});
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_iread;
        bit seen, is_d; logic [31:0] load; logic ow; exp_t e;
        @(negedge clk);
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = FREE;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        @(negedge clk);
        bus.iaddr = 32'h44;
        #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN} !== 2'b10 || bus.ramaddr !== 32'h40) begin
            errors++; $display("FAIL iread_ram: got ren/wen=%b addr=%h want 10 addr=00000040",
                               {bus.ramREN, bus.ramWEN}, bus.ramaddr);
        end
        await_pulse(32'h40 ^ 32'hDEADBEEF, 1, 10, seen, is_d, load, ow);
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++; $display("FAIL iread_timeout: got no iwait pulse want one");
        end else if (is_d !== e.is_d || load !== e.data || ow !== 1'b1) begin
            errors++; $display("FAIL iread_pulse: got is_d=%0b load=%h dwait=%b want is_d=%0b load=%h dwait=1",
                               is_d, load, ow, e.is_d, e.data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.iwait !== 1'b1 || bus.iload !== 32'h0) begin
            errors++; $display("FAIL iread_single: got iwait=%b iload=%h want 1 0", bus.iwait, bus.iload);
        end
        bus.iREN = 1'b0;
    endtask

    task automatic test_dwrite;
        bit seen, is_d; logic [31:0] load; logic ow;
        @(negedge clk);
        bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h12345678;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.ramWEN, bus.ramREN} !== 2'b10 || bus.ramstore !== 32'h12345678 || bus.ramaddr !== 32'h100) begin
            errors++; $display("FAIL dwrite_ram: got wen/ren=%b store=%h addr=%h want 10 12345678 00000100",
                               {bus.ramWEN, bus.ramREN}, bus.ramstore, bus.ramaddr);
        end
        await_pulse(32'h0, 1, 10, seen, is_d, load, ow);
        checks++;
        if (!seen || is_d !== 1'b1 || ow !== 1'b1) begin
            errors++; $display("FAIL dwrite_pulse: got seen=%0b is_d=%0b iwait=%b want 1 1 1", seen, is_d, ow);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.dwait !== 1'b1) begin
            errors++; $display("FAIL dwrite_single: got dwait=%b want 1", bus.dwait);
        end
        bus.dWEN = 1'b0; bus.dREN = 1'b0;
    endtask

    task automatic test_alternate;
        bit seen, is_d; logic [31:0] load; logic ow; exp_t e;
        logic [31:0] salt = 32'h5A5A0000;
        @(negedge clk);
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        bus.iREN = 1'b1; bus.iaddr = 32'h200; bus.dREN = 1'b1; bus.daddr = 32'h300;
        for (int n = 0; n < 2; n++) begin
            sb.push_back('{1'b1, 32'h300 ^ salt});
            sb.push_back('{1'b0, 32'h200 ^ salt});
        end
        for (int n = 0; n < 4; n++) begin
            await_pulse(salt, 1, 10, seen, is_d, load, ow);
            e = sb.pop_front();
            checks++;
            if (!seen || is_d !== e.is_d || load !== e.data || ow !== 1'b1) begin
                errors++; $display("FAIL alt_grant%0d: got seen=%0b is_d=%0b load=%h other_wait=%b want 1 %0b %h 1",
                                   n, seen, is_d, load, ow, e.is_d, e.data);
            end
        end
        @(negedge clk);
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    endtask

    task automatic test_error;
        bit seen, is_d; logic [31:0] load; logic ow; exp_t e;
        @(negedge clk);
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.ramload = 32'hBAD0BAD0; bus.ramstate = ERROR;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.ramstate = ERROR;
            #1;
            checks++;
            if (bus.iwait !== (k == 3 ? 1'b0 : 1'b1) || bus.ramREN !== 1'b1 || bus.ram_err !== 1'b0) begin
                errors++; $display("FAIL err_cycle%0d: got iwait=%b ramREN=%b ram_err=%b want %b 1 0",
                                   k, bus.iwait, bus.ramREN, bus.ram_err, (k == 3 ? 1'b0 : 1'b1));
            end
        end
        checks++;
        if (bus.iload !== 32'hBAD0BAD0) begin
            errors++; $display("FAIL err_load: got %h want BAD0BAD0", bus.iload);
        end
        @(negedge clk);
        bus.iREN = 1'b0; bus.ramstate = FREE;
        #1;
        checks++;
        if (bus.ram_err !== 1'b1 || bus.iwait !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got ram_err=%b iwait=%b want 1 1", bus.ram_err, bus.iwait);
        end
        bus.dREN = 1'b1; bus.daddr = 32'h700;
        sb.push_back('{1'b1, 32'h700 ^ 32'h00FF00FF});
        await_pulse(32'h00FF00FF, 0, 10, seen, is_d, load, ow);
        e = sb.pop_front();
        checks++;
        if (!seen || is_d !== e.is_d || load !== e.data || bus.ram_err !== 1'b1) begin
            errors++; $display("FAIL err_after: got seen=%0b is_d=%0b load=%h ram_err=%b want 1 %0b %h 1",
                               seen, is_d, load, bus.ram_err, e.is_d, e.data);
        end
        @(negedge clk);
        bus.dREN = 1'b0; bus.ramstate = FREE;
    endtask

    task automatic test_abort;
        @(negedge clk);
        bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramstate = BUSY;
        @(negedge clk);
        #1;
        checks++;
        if (bus.ramREN !== 1'b1 || bus.dwait !== 1'b1) begin
            errors++; $display("FAIL abort_pre: got ramREN=%b dwait=%b want 1 1", bus.ramREN, bus.dwait);
        end
        bus.dREN = 1'b0;
        #1;
        checks++;
        if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1 || bus.dload !== 32'h0) begin
            errors++; $display("FAIL abort_drop: got ramREN=%b dwait=%b dload=%h want 0 1 0",
                               bus.ramREN, bus.dwait, bus.dload);
        end
        @(negedge clk);
        bus.ramstate = ACCESS;
        #1;
        checks++;
        if (bus.dwait !== 1'b1 || bus.ramREN !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got dwait=%b ramREN=%b want 1 0", bus.dwait, bus.ramREN);
        end
        bus.ramstate = FREE;
    endtask

    task automatic test_reset_mid;
        bit seen, is_d; logic [31:0] load; logic ow; exp_t e;
        @(negedge clk);
        bus.dWEN = 1'b1; bus.daddr = 32'h900; bus.dstore = 32'hCAFEF00D; bus.ramstate = BUSY;
        @(negedge clk);
        #1;
        checks++;
        if (bus.ramWEN !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got ramWEN=%b want 1", bus.ramWEN);
        end
        nrst = 1'b0; bus.ramstate = ACCESS;
        #1;
        checks++;
        if ({bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait} !== 4'b0011 ||
            bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin
            errors++; $display("FAIL rstmid_async: got wen/ren/dwait/iwait=%b addr=%h store=%h want 0011 0 0",
                               {bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait}, bus.ramaddr, bus.ramstore);
        end
        @(negedge clk);
        nrst = 1'b1; bus.dWEN = 1'b0; bus.ramstate = FREE;
        bus.iREN = 1'b1; bus.iaddr = 32'h600;
        sb.push_back('{1'b0, 32'h600 ^ 32'h13572468});
        await_pulse(32'h13572468, 1, 10, seen, is_d, load, ow);
        e = sb.pop_front();
        checks++;
        if (!seen || is_d !== e.is_d || load !== e.data || ow !== 1'b1) begin
            errors++; $display("FAIL rstmid_after: got seen=%0b is_d=%0b load=%h dwait=%b want 1 %0b %h 1",
                               seen, is_d, load, ow, e.is_d, e.data);
        end
        @(negedge clk);
        bus.iREN = 1'b0;
    endtask

    initial begin
        nrst = 1'b1;
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
        #2 nrst = 1'b0;
        test_reset;
        test_iread;
        test_dwrite;
        test_alternate;
        test_error;
        test_abort;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
